// File: rtl/rv32v_types_pkg.sv
// rv32v_types_pkg: shared vector types, element-width encoding and collector FSM states.
package rv32v_types_pkg;
  localparam int NUM_LANES = 4;
  localparam int DCACHE_BLOCK_SIZE = 8;
  typedef enum logic [1:0] {SEW8 = 2'd0, SEW16 = 2'd1, SEW32 = 2'd2, SEW64 = 2'd3} vsew_t;
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2} collector_state_t;
endpackage

// File: rtl/rv32v_elem_extract.sv
// rv32v_elem_extract: pick one element out of a 32b word by byte offset and EEW, zero-extended.
//  word  in  32  response word containing the element
//  addr  in  2   element byte offset within the word
//  veew  in  vsew_t element width (e8/e16/e32; e64 passes the word through)
//  elem  out 32  zero-extended element
module rv32v_elem_extract
  import rv32v_types_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  vsew_t       veew,
  output logic [31:0] elem
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word[{addr, 3'b000} +: 8];
  assign h = word[{addr[1], 4'b0000} +: 16];
  assign elem = veew == SEW8 ? {24'h0, b} : veew == SEW16 ? {16'h0, h} : word;
endmodule

// File: rtl/rv32v_load_collector.sv
// rv32v_load_collector: gathers LSC load responses into per-lane element data for one vector load uop.
//  CLK/RST (sync, active-high); start/start_ready + lane_mask/lane_addr/veew/uop_num/uop_last latch a uop;
//  rsp_valid/rsp_wide/rsp_lanes/rsp_lane/rsp_word/rsp_block deliver wide or narrow responses;
//  out_valid/out_ready handshake out_data/out_mask/out_uop_num/out_uop_last.
//  RV32V_LOAD_FAULT_EN adds rsp_fault, out_fault, out_fault_lane (fault-only-first truncation).
module rv32v_load_collector
  import rv32v_types_pkg::*;
#(
  parameter int LANES = NUM_LANES,
  parameter int BLOCK_WORDS = DCACHE_BLOCK_SIZE
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  output logic                         start_ready,
  input  logic [LANES-1:0]             lane_mask,
  input  logic [LANES*32-1:0]          lane_addr,
  input  vsew_t                        veew,
  input  logic [4:0]                   uop_num,
  input  logic                         uop_last,
  input  logic                         rsp_valid,
  input  logic                         rsp_wide,
  input  logic [LANES-1:0]             rsp_lanes,
  input  logic [$clog2(LANES)-1:0]     rsp_lane,
  input  logic [31:0]                  rsp_word,
  input  logic [BLOCK_WORDS*32-1:0]    rsp_block,
`ifdef RV32V_LOAD_FAULT_EN
  input  logic                         rsp_fault,
  output logic                         out_fault,
  output logic [$clog2(LANES)-1:0]     out_fault_lane,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*32-1:0]          out_data,
  output logic [LANES-1:0]             out_mask,
  output logic [4:0]                   out_uop_num,
  output logic                         out_uop_last
);
  localparam int LW = $clog2(LANES);
  localparam int IW = $clog2(BLOCK_WORDS);
  collector_state_t state_q, state_d;
  logic [LANES-1:0] pending_q, pending_d, mask_q, mask_d, hit;
  logic [LANES-1:0][31:0] data_q, data_d, elem;
  logic [LANES-1:0][IW+1:0] addr_q, addr_d;
  vsew_t veew_q, veew_d;
  logic [4:0] uop_num_q, uop_num_d;
  logic uop_last_q, uop_last_d;
  logic [BLOCK_WORDS-1:0][31:0] blk;
  logic accept;
  logic unused_addr;
`ifdef RV32V_LOAD_FAULT_EN
  logic fault_q, fault_d;
  logic [LW-1:0] fault_lane_q, fault_lane_d, first_hit;
`endif
  assign blk = rsp_block;
  // Only the word-select and byte-offset bits of each address are kept.
  assign unused_addr = ^lane_addr;
  assign start_ready = state_q == IDLE || (state_q == DONE && out_ready);
  assign accept = start && start_ready;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0] word;
    assign word = rsp_wide ? blk[addr_q[i][IW+1:2]] : rsp_word;
    assign hit[i] = rsp_valid && state_q == COLLECT && pending_q[i] &&
                    (rsp_wide ? rsp_lanes[i] : rsp_lane == LW'(i));
    rv32v_elem_extract u_ext (.word(word), .addr(addr_q[i][1:0]), .veew(veew_q), .elem(elem[i]));
  end
  always_comb begin
    state_d = state_q;
    pending_d = pending_q;
    mask_d = mask_q;
    data_d = data_q;
    addr_d = addr_q;
    veew_d = veew_q;
    uop_num_d = uop_num_q;
    uop_last_d = uop_last_q;
`ifdef RV32V_LOAD_FAULT_EN
    fault_d = fault_q;
    fault_lane_d = fault_lane_q;
    first_hit = '0;
    for (int i = LANES - 1; i >= 0; i--) if (hit[i]) first_hit = LW'(i);
`endif
    if (state_q == COLLECT) begin
      for (int i = 0; i < LANES; i++) begin
        if (hit[i]) begin
          data_d[i] = elem[i];
          pending_d[i] = 1'b0;
        end
      end
`ifdef RV32V_LOAD_FAULT_EN
      // Fault-only-first: truncate the uop at the lowest faulting lane.
      if (rsp_fault && |hit) begin
        fault_d = 1'b1;
        fault_lane_d = first_hit;
        pending_d = '0;
        for (int i = 0; i < LANES; i++) begin
          if (i >= int'(first_hit)) begin
            data_d[i] = '0;
            mask_d[i] = 1'b0;
          end
        end
      end
`endif
      if (pending_d == '0) state_d = DONE;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
    // A start in DONE with out_ready reloads directly, giving back-to-back uops.
    if (accept) begin
      state_d = lane_mask == '0 ? DONE : COLLECT;
      pending_d = lane_mask;
      mask_d = lane_mask;
      data_d = '0;
      for (int i = 0; i < LANES; i++) addr_d[i] = lane_addr[i*32 +: IW+2];
      veew_d = veew;
      uop_num_d = uop_num;
      uop_last_d = uop_last;
`ifdef RV32V_LOAD_FAULT_EN
      fault_d = 1'b0;
      fault_lane_d = '0;
`endif
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pending_q <= '0;
      mask_q <= '0;
      data_q <= '0;
      addr_q <= '0;
      veew_q <= SEW8;
      uop_num_q <= '0;
      uop_last_q <= 1'b0;
`ifdef RV32V_LOAD_FAULT_EN
      fault_q <= 1'b0;
      fault_lane_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      mask_q <= mask_d;
      data_q <= data_d;
      addr_q <= addr_d;
      veew_q <= veew_d;
      uop_num_q <= uop_num_d;
      uop_last_q <= uop_last_d;
`ifdef RV32V_LOAD_FAULT_EN
      fault_q <= fault_d;
      fault_lane_q <= fault_lane_d;
`endif
    end
  end
  assign out_valid = state_q == DONE;
  assign out_data = data_q;
  assign out_mask = mask_q;
  assign out_uop_num = uop_num_q;
  assign out_uop_last = uop_last_q;
`ifdef RV32V_LOAD_FAULT_EN
  assign out_fault = fault_q;
  assign out_fault_lane = fault_lane_q;
`endif
endmodule

// File: tb/tb_rv32v_load_collector.sv
// tb_rv32v_load_collector: directed self-checking bench for rv32v_load_collector (LANES=4, BLOCK_WORDS=8).
module tb_rv32v_load_collector;
  import rv32v_types_pkg::*;
  logic CLK = 1'b0, RST = 1'b1;
  logic start = 1'b0, start_ready;
  logic [3:0] lane_mask = '0;
  logic [3:0][31:0] lane_addr = '0;
  vsew_t veew = SEW32;
  logic [4:0] uop_num = '0;
  logic uop_last = 1'b0;
  logic rsp_valid = 1'b0, rsp_wide = 1'b0;
  logic [3:0] rsp_lanes = '0;
  logic [1:0] rsp_lane = '0;
  logic [31:0] rsp_word = '0;
  logic [7:0][31:0] rsp_block = '0;
  logic out_valid, out_ready = 1'b0;
  logic [3:0][31:0] out_data;
  logic [3:0] out_mask;
  logic [4:0] out_uop_num;
  logic out_uop_last;
`ifdef RV32V_LOAD_FAULT_EN
  logic rsp_fault = 1'b0, out_fault;
  logic [1:0] out_fault_lane;
`endif
  int errors = 0, checks = 0;

  rv32v_load_collector #(.LANES(4), .BLOCK_WORDS(8)) dut (
    .CLK(CLK), .RST(RST), .start(start), .start_ready(start_ready),
    .lane_mask(lane_mask), .lane_addr(lane_addr), .veew(veew), .uop_num(uop_num), .uop_last(uop_last),
    .rsp_valid(rsp_valid), .rsp_wide(rsp_wide), .rsp_lanes(rsp_lanes), .rsp_lane(rsp_lane),
    .rsp_word(rsp_word), .rsp_block(rsp_block),
`ifdef RV32V_LOAD_FAULT_EN
    .rsp_fault(rsp_fault), .out_fault(out_fault), .out_fault_lane(out_fault_lane),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
    .out_uop_num(out_uop_num), .out_uop_last(out_uop_last)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input logic [3:0] m, input logic [3:0][31:0] a, input vsew_t e,
                          input logic [4:0] n, input logic l);
    start = 1'b1; lane_mask = m; lane_addr = a; veew = e; uop_num = n; uop_last = l;
    tick();
    start = 1'b0;
  endtask

  task automatic narrow(input logic [1:0] lane, input logic [31:0] w, input logic f);
    rsp_valid = 1'b1; rsp_wide = 1'b0; rsp_lane = lane; rsp_word = w;
`ifdef RV32V_LOAD_FAULT_EN
    rsp_fault = f;
`endif
    tick();
    rsp_valid = 1'b0;
`ifdef RV32V_LOAD_FAULT_EN
    rsp_fault = 1'b0;
`else
    if (f) $display("note: fault stimulus ignored in this build");
`endif
  endtask

  task automatic wide(input logic [3:0] lanes, input logic [7:0][31:0] blk);
    rsp_valid = 1'b1; rsp_wide = 1'b1; rsp_lanes = lanes; rsp_block = blk;
    tick();
    rsp_valid = 1'b0; rsp_wide = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_data got=%h want=0", out_data); end
    checks++; if (out_mask !== 4'h0) begin errors++; $display("FAIL reset_mask got=%b want=0000", out_mask); end
    checks++; if (out_uop_num !== 5'd0 || out_uop_last !== 1'b0) begin errors++; $display("FAIL reset_uop got=%0d/%0b want=0/0", out_uop_num, out_uop_last); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b want=1", start_ready); end
  endtask

  task automatic test_wide();
    logic [7:0][31:0] blk;
    logic [3:0][31:0] exp;
    for (int k = 0; k < 8; k++) blk[k] = 32'hA000_0000 | k;
    do_start(4'b1111, {32'h10C, 32'h108, 32'h104, 32'h100}, SEW32, 5'd3, 1'b1);
    checks++; if (out_valid !== 1'b0 || start_ready !== 1'b0) begin errors++; $display("FAIL wide_collect got=valid%0b/ready%0b want=0/0", out_valid, start_ready); end
    wide(4'b1111, blk);
    exp = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wide_valid got=%0b want=1", out_valid); end
    checks++; if (out_data !== exp) begin errors++; $display("FAIL wide_data got=%h want=%h", out_data, exp); end
    checks++; if (out_uop_num !== 5'd3 || out_uop_last !== 1'b1 || out_mask !== 4'b1111) begin errors++; $display("FAIL wide_echo got=%0d/%0b/%b want=3/1/1111", out_uop_num, out_uop_last, out_mask); end
    drain();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wide_drain got=%0b want=0", out_valid); end
    blk[7] = 32'h1234_5678; blk[1] = 32'h9ABC_DEF0;
    do_start(4'b0011, {32'h0, 32'h0, 32'h104, 32'h11E}, SEW16, 5'd4, 1'b0);
    wide(4'b1111, blk);
    exp = {32'h0, 32'h0, 32'h0000_DEF0, 32'h0000_1234};
    checks++; if (out_valid !== 1'b1 || out_data !== exp) begin errors++; $display("FAIL wide_e16 got=%0b/%h want=1/%h", out_valid, out_data, exp); end
    drain();
  endtask

  task automatic test_narrow_e8();
    logic [3:0][31:0] exp;
    do_start(4'b0011, {32'h0, 32'h0, 32'h202, 32'h201}, SEW8, 5'd1, 1'b0);
    narrow(2'd0, 32'hAABB_CCDD, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL e8_early got=%0b want=0", out_valid); end
    narrow(2'd1, 32'hAABB_CCDD, 1'b0);
    exp = {32'h0, 32'h0, 32'h0000_00BB, 32'h0000_00CC};
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL e8_valid got=%0b want=1", out_valid); end
    checks++; if (out_data !== exp) begin errors++; $display("FAIL e8_data got=%h want=%h", out_data, exp); end
    drain();
  endtask

  task automatic test_partial_mask();
    logic [3:0][31:0] exp;
    do_start(4'b0101, {32'h30C, 32'h308, 32'h304, 32'h300}, SEW32, 5'd2, 1'b0);
    narrow(2'd0, 32'h1111_1111, 1'b0);
    narrow(2'd1, 32'h2222_2222, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stray_valid got=%0b want=0", out_valid); end
    narrow(2'd2, 32'h3333_3333, 1'b0);
    exp = {32'h0, 32'h3333_3333, 32'h0, 32'h1111_1111};
    checks++; if (out_valid !== 1'b1 || out_data !== exp) begin errors++; $display("FAIL partial_data got=%0b/%h want=1/%h", out_valid, out_data, exp); end
    checks++; if (out_mask !== 4'b0101) begin errors++; $display("FAIL partial_mask got=%b want=0101", out_mask); end
    narrow(2'd0, 32'hFFFF_FFFF, 1'b0);
    checks++; if (out_data !== exp) begin errors++; $display("FAIL done_ignore got=%h want=%h", out_data, exp); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [3:0][31:0] exp;
    do_start(4'b0001, {32'h0, 32'h0, 32'h0, 32'h400}, SEW32, 5'd7, 1'b0);
    narrow(2'd0, 32'hCAFE_F00D, 1'b0);
    exp = {32'h0, 32'h0, 32'h0, 32'hCAFE_F00D};
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp || out_uop_num !== 5'd7) begin errors++; $display("FAIL hold_%0d got=%0b/%h/%0d want=1/%h/7", c, out_valid, out_data, out_uop_num, exp); end
      checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_%0d got=%0b want=0", c, start_ready); end
      tick();
    end
    out_ready = 1'b1;
    #0;
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%0b want=1", start_ready); end
    do_start(4'b0010, {32'h0, 32'h0, 32'h504, 32'h0}, SEW32, 5'd8, 1'b1);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_uop_num !== 5'd8 || out_mask !== 4'b0010) begin errors++; $display("FAIL b2b_accept got=%0b/%0d/%b want=0/8/0010", out_valid, out_uop_num, out_mask); end
    do_start(4'b1111, {32'h0, 32'h0, 32'h0, 32'h0}, SEW32, 5'd9, 1'b0);
    checks++; if (out_uop_num !== 5'd8 || out_mask !== 4'b0010) begin errors++; $display("FAIL drop_start got=%0d/%b want=8/0010", out_uop_num, out_mask); end
    narrow(2'd1, 32'h0BAD_BEEF, 1'b0);
    exp = {32'h0, 32'h0, 32'h0BAD_BEEF, 32'h0};
    checks++; if (out_valid !== 1'b1 || out_data !== exp) begin errors++; $display("FAIL b2b_data got=%0b/%h want=1/%h", out_valid, out_data, exp); end
    drain();
  endtask

  task automatic test_zero_mask_reset();
    do_start(4'b0000, {32'h0, 32'h0, 32'h0, 32'h0}, SEW32, 5'd5, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 128'h0 || out_mask !== 4'h0 || out_uop_num !== 5'd5) begin errors++; $display("FAIL zero_mask got=%0b/%h/%b/%0d want=1/0/0000/5", out_valid, out_data, out_mask, out_uop_num); end
    drain();
    do_start(4'b1111, {32'h60C, 32'h608, 32'h604, 32'h600}, SEW32, 5'd6, 1'b1);
    narrow(2'd0, 32'h5555_5555, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (out_valid !== 1'b0 || start_ready !== 1'b1 || out_uop_num !== 5'd0 || out_data !== 128'h0) begin errors++; $display("FAIL mid_reset got=%0b/%0b/%0d/%h want=0/1/0/0", out_valid, start_ready, out_uop_num, out_data); end
    narrow(2'd1, 32'h1, 1'b0);
    narrow(2'd2, 32'h2, 1'b0);
    narrow(2'd3, 32'h3, 1'b0);
    checks++; if (out_valid !== 1'b0 || out_data !== 128'h0) begin errors++; $display("FAIL idle_ignore got=%0b/%h want=0/0", out_valid, out_data); end
  endtask

`ifdef RV32V_LOAD_FAULT_EN
  task automatic test_fault();
    logic [3:0][31:0] exp;
    do_start(4'b1111, {32'h70C, 32'h708, 32'h704, 32'h700}, SEW32, 5'd10, 1'b0);
    narrow(2'd0, 32'h10, 1'b0);
    narrow(2'd1, 32'h11, 1'b0);
    narrow(2'd2, 32'h12, 1'b1);
    exp = {32'h0, 32'h0, 32'h11, 32'h10};
    checks++; if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_fault_lane !== 2'd2) begin errors++; $display("FAIL fault_flag got=%0b/%0b/%0d want=1/1/2", out_valid, out_fault, out_fault_lane); end
    checks++; if (out_mask !== 4'b0011 || out_data !== exp) begin errors++; $display("FAIL fault_data got=%b/%h want=0011/%h", out_mask, out_data, exp); end
    out_ready = 1'b1;
    do_start(4'b0001, {32'h0, 32'h0, 32'h0, 32'h800}, SEW32, 5'd11, 1'b0);
    out_ready = 1'b0;
    checks++; if (out_fault !== 1'b0 || out_fault_lane !== 2'd0) begin errors++; $display("FAIL fault_clear got=%0b/%0d want=0/0", out_fault, out_fault_lane); end
    narrow(2'd0, 32'h99, 1'b0);
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_wide();
    test_narrow_e8();
    test_partial_mask();
    test_back_to_back();
    test_zero_mask_reset();
`ifdef RV32V_LOAD_FAULT_EN
    test_fault();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
